// File: rtl/pwm_pkg.sv
// Shared constants for the pwm_counter_gen timebase: default sizes, reset
// value of the active period and the up/down direction encoding.
package pwm_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_CHANNELS = 2;
    localparam int DEF_PRESC_W  = 8;

    // Replicated to WIDTH bits, so the active period comes out of reset as all ones.
    localparam logic PERIOD_RST_BIT = 1'b1;

    localparam logic UP   = 1'b0;
    localparam logic DOWN = 1'b1;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock prescaler: counts 0..presc while enabled and flags tick on the last
// count. A presc lowered below the running count wraps it to 0 on the next clock.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESC_W = DEF_PRESC_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [PRESC_W-1:0] presc,
    output logic               tick
);

    logic [PRESC_W-1:0] cnt;

    assign tick = en && (cnt == presc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (en) begin
            // NOTE: sequential state uses non-blocking assignments only
            cnt <= (cnt >= presc) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_counter_gen.sv
// Multi-channel PWM timebase: one shared counter, per-channel duty compare and
// shadowed PERIOD/DUTY updates at the wrap. Define PWM_CENTER_ALIGNED_EN for MODE.
module pwm_counter_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int CHANNELS = DEF_CHANNELS,
    parameter int PRESC_W  = DEF_PRESC_W
) (
    input  logic                      CLoK,
    input  logic                      RST_N,
    input  logic                      EN,
    input  logic [PRESC_W-1:0]        PRESC,
    input  logic [WIDTH-1:0]          PERIOD,
    input  logic [CHANNELS*WIDTH-1:0] DUTY,
    input  logic                      LOAD,
`ifdef PWM_CENTER_ALIGNED_EN
    input  logic                      MODE,
`endif
    output logic [WIDTH-1:0]          CNTR,
    output logic [CHANNELS-1:0]       PWM_OUT,
    output logic                      PERIOD_END,
    output logic                      LOAD_ACK
);

    logic                      tick;
    logic                      wrap;
    logic                      pending;
    logic [WIDTH-1:0]          cntr_q;
    logic [WIDTH-1:0]          cntr_nxt;
    logic [WIDTH-1:0]          act_period;
    logic [WIDTH-1:0]          pend_period;
    logic [CHANNELS*WIDTH-1:0] act_duty;
    logic [CHANNELS*WIDTH-1:0] pend_duty;
    logic [CHANNELS*WIDTH-1:0] duty_nxt;
    logic [CHANNELS-1:0]       pwm_q;
    logic [CHANNELS-1:0]       pwm_nxt;

    pwm_prescaler #(.PRESC_W(PRESC_W)) u_prescaler (
        .clk   (CLoK),
        .rst_n (RST_N),
        .en    (EN),
        .presc (PRESC),
        .tick  (tick)
    );

`ifdef PWM_CENTER_ALIGNED_EN
    logic dir_q;
    logic dir_nxt;
    logic center_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no latch is inferred
        cntr_nxt = cntr_q;
        dir_nxt  = dir_q;
        if (!center_q || act_period == '0) begin
            cntr_nxt = (cntr_q == act_period) ? '0 : cntr_q + 1'b1;
            dir_nxt  = UP;
        end else if (dir_q == UP) begin
            if (cntr_q >= act_period) begin
                cntr_nxt = cntr_q - 1'b1;
                dir_nxt  = DOWN;
            end else begin
                cntr_nxt = cntr_q + 1'b1;
            end
        end else begin
            cntr_nxt = cntr_q - 1'b1;
            if (cntr_nxt == '0) dir_nxt = UP;
        end
    end

    always_ff @(posedge CLoK or negedge RST_N) begin
        if (!RST_N) begin
            dir_q    <= UP;
            center_q <= 1'b0;
        end else if (tick) begin
            dir_q <= dir_nxt;
            if (wrap) center_q <= MODE;
        end
    end
`else
    // The counter never exceeds the active period, so +1 cannot overflow here.
    assign cntr_nxt = (cntr_q == act_period) ? '0 : cntr_q + 1'b1;
`endif

    // Every wrap is a tick whose next count is 0, in either counting mode.
    assign wrap       = tick && (cntr_nxt == '0);
    assign PERIOD_END = wrap;
    assign LOAD_ACK   = wrap && pending;
    assign duty_nxt   = (wrap && pending) ? pend_duty : act_duty;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        assign pwm_nxt[i] = {1'b0, cntr_nxt} < {1'b0, duty_nxt[i*WIDTH +: WIDTH]};
    end

    always_ff @(posedge CLoK or negedge RST_N) begin
        if (!RST_N) begin
            cntr_q      <= '0;
            pwm_q       <= '0;
            act_period  <= {WIDTH{PERIOD_RST_BIT}};
            act_duty    <= '0;
            pend_period <= '0;
            pend_duty   <= '0;
            pending     <= 1'b0;
        end else begin
            if (tick) begin
                cntr_q <= cntr_nxt;
                pwm_q  <= pwm_nxt;
            end
            if (wrap && pending) begin
                act_period <= pend_period;
                act_duty   <= pend_duty;
                pending    <= 1'b0;
            end
            // A LOAD on the wrap cycle lands after the swap above and waits for the next wrap.
            if (LOAD) begin
                pend_period <= PERIOD;
                pend_duty   <= DUTY;
                pending     <= 1'b1;
            end
        end
    end

    assign CNTR    = cntr_q;
    assign PWM_OUT = pwm_q;

endmodule

// File: tb/tb_pwm_counter_gen.sv
// Self-checking bench for pwm_counter_gen: directed scenarios with measured
// period/duty figures plus a randomized run against a behavioural model.
module tb_pwm_counter_gen;

    localparam int W  = 8;
    localparam int CH = 2;
    localparam int PW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            load;
    logic [PW-1:0]   presc;
    logic [W-1:0]    period;
    logic [CH*W-1:0] duty;
    logic [W-1:0]    cntr;
    logic [CH-1:0]   pwm_out;
    logic            period_end;
    logic            load_ack;
`ifdef PWM_CENTER_ALIGNED_EN
    logic            mode = 1'b0;
`endif

    always #5 clk = ~clk;

    pwm_counter_gen #(.WIDTH(W), .CHANNELS(CH), .PRESC_W(PW)) dut (
        .CLoK       (clk),
        .RST_N      (rst_n),
        .EN         (en),
        .PRESC      (presc),
        .PERIOD     (period),
        .DUTY       (duty),
        .LOAD       (load),
`ifdef PWM_CENTER_ALIGNED_EN
        .MODE       (mode),
`endif
        .CNTR       (cntr),
        .PWM_OUT    (pwm_out),
        .PERIOD_END (period_end),
        .LOAD_ACK   (load_ack)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Behavioural model: tick phase, count position, active/pending settings.
    int            m_pre, m_cnt, m_per, m_pend, p_per;
    int            m_duty[CH];
    int            p_duty[CH];
    logic [CH-1:0] m_pwm;

    task automatic model_reset();
        m_pre  = 0;
        m_cnt  = 0;
        m_per  = (1 << W) - 1;
        m_pend = 0;
        p_per  = 0;
        m_pwm  = '0;
        for (int i = 0; i < CH; i++) begin
            m_duty[i] = 0;
            p_duty[i] = 0;
        end
    endtask

    logic          o_pe, o_ack;
    logic [W-1:0]  o_cntr;
    logic [CH-1:0] o_pwm;

    // One clock: sample just after the falling edge, compare, advance the model.
    task automatic cycle();
        bit tick, wrap;
        #1;
        o_pe   = period_end;
        o_ack  = load_ack;
        o_cntr = cntr;
        o_pwm  = pwm_out;
        tick = en && (m_pre == int'(presc));
        wrap = tick && (m_cnt == m_per);
        check("cntr", o_cntr, m_cnt);
        check("pwm_out", o_pwm, m_pwm);
        check("period_end", o_pe, wrap);
        check("load_ack", o_ack, wrap && (m_pend != 0));
        if (en) m_pre = (m_pre >= int'(presc)) ? 0 : m_pre + 1;
        if (tick) begin
            if (wrap) begin
                m_cnt = 0;
                if (m_pend != 0) begin
                    m_per  = p_per;
                    m_duty = p_duty;
                    m_pend = 0;
                end
            end else begin
                m_cnt++;
            end
            for (int i = 0; i < CH; i++) m_pwm[i] = (m_cnt < m_duty[i]);
        end
        if (load) begin
            p_per = int'(period);
            for (int i = 0; i < CH; i++) p_duty[i] = int'(duty[i*W +: W]);
            m_pend = 1;
        end
        @(negedge clk);
    endtask

    task automatic set_duty(input int d0, input int d1);
        duty = {W'(d1), W'(d0)};
    endtask

    task automatic do_load(input int per, input int d0, input int d1);
        period = W'(per);
        set_duty(d0, d1);
        load = 1'b1;
        cycle();
        load = 1'b0;
    endtask

    task automatic wait_wrap(input string tag, input int budget);
        bit seen = 1'b0;
        for (int k = 0; k < budget && !seen; k++) begin
            cycle();
            seen = o_pe;
        end
        check(tag, seen, 1);
    endtask

    task automatic measure(input int n, output int hi0, output int hi1,
                           output int pes, output int acks, output int last_pe);
        hi0 = 0; hi1 = 0; pes = 0; acks = 0; last_pe = 0;
        for (int k = 0; k < n; k++) begin
            cycle();
            hi0 += int'(o_pwm[0]);
            hi1 += int'(o_pwm[1]);
            pes += int'(o_pe);
            acks += int'(o_ack);
            last_pe = int'(o_pe);
        end
    endtask

    initial begin
        int hi0, hi1, pes, acks, last_pe, len;
        rst_n = 1'b0; en = 1'b1; load = 1'b0;
        presc = '0; period = '0; duty = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_cntr", cntr, 0);
        check("rst_pwm", pwm_out, 0);
        check("rst_period_end", period_end, 0);
        check("rst_load_ack", load_ack, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-count with a load still pending.
        do_load(9, 3, 7);
        repeat (4) cycle();
        #2;
        check("pre_reset_cntr", cntr, 5);
        rst_n = 1'b0;
        #1;
        check("async_rst_cntr", cntr, 0);
        check("async_rst_pwm", pwm_out, 0);
        check("async_rst_period_end", period_end, 0);
        check("async_rst_load_ack", load_ack, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        len = 0;
        for (int k = 1; k <= 300 && len == 0; k++) begin
            cycle();
            if (o_pe) len = k;
        end
        check("first_period_len", len, 256);
        check("first_period_no_ack", o_ack, 0);

        // Shadow load of period 9, duties 3 and 7.
        do_load(9, 3, 7);
        wait_wrap("t2_wrap", 300);
        check("t2_ack_at_wrap", o_ack, 1);
        measure(10, hi0, hi1, pes, acks, last_pe);
        check("t2_hi0", hi0, 3);
        check("t2_hi1", hi1, 7);
        check("t2_pe_count", pes, 1);
        check("t2_pe_last", last_pe, 1);

        // Prescale by 3.
        presc = PW'(2);
        wait_wrap("t3_wrap", 40);
        measure(30, hi0, hi1, pes, acks, last_pe);
        check("t3_hi0", hi0, 9);
        check("t3_hi1", hi1, 21);
        check("t3_pe_count", pes, 1);
        check("t3_pe_last", last_pe, 1);
        presc = '0;

        // Duty boundaries and zero period.
        do_load(9, 0, 10);
        wait_wrap("t4a_wrap", 20);
        measure(10, hi0, hi1, pes, acks, last_pe);
        check("t4_duty0_low", hi0, 0);
        check("t4_duty10_high", hi1, 10);
        do_load(9, 0, 255);
        wait_wrap("t4b_wrap", 20);
        measure(10, hi0, hi1, pes, acks, last_pe);
        check("t4_duty255_high", hi1, 10);
        do_load(0, 3, 7);
        wait_wrap("t4c_wrap", 20);
        measure(5, hi0, hi1, pes, acks, last_pe);
        check("t4_period0_pe", pes, 5);
        check("t4_period0_hi0", hi0, 5);

        // Load mid-period, then a second load exactly on the wrap cycle.
        do_load(9, 3, 7);
        wait_wrap("t5_sync", 20);
        measure(10, hi0, hi1, pes, acks, last_pe);
        check("t5_sync_last", last_pe, 1);
        repeat (4) cycle();
        do_load(9, 5, 7);
        measure(5, hi0, hi1, pes, acks, last_pe);
        check("t5_old_duty_held", hi0, 0);
        check("t5_ack_at_wrap", acks, 1);
        check("t5_wrap_last", last_pe, 1);
        measure(10, hi0, hi1, pes, acks, last_pe);
        check("t5_new_duty", hi0, 5);
        repeat (4) cycle();
        do_load(9, 2, 7);
        repeat (4) cycle();
        do_load(9, 6, 7);
        check("t5_wrap_load_pe", o_pe, 1);
        check("t5_wrap_load_ack", o_ack, 1);
        measure(10, hi0, hi1, pes, acks, last_pe);
        check("t5_first_applied", hi0, 2);
        check("t5_second_ack", acks, 1);
        measure(10, hi0, hi1, pes, acks, last_pe);
        check("t5_second_applied", hi0, 6);

        // Enable freeze at count 6.
        repeat (6) cycle();
        en = 1'b0;
        for (int k = 0; k < 7; k++) begin
            cycle();
            check("t6_frozen_cntr", o_cntr, 6);
            check("t6_frozen_pe", o_pe, 0);
        end
        en = 1'b1;
        cycle();
        check("t6_resume_cntr", o_cntr, 6);
        cycle();
        check("t6_advance_cntr", o_cntr, 7);

        // Randomized traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 49) == 0) presc = PW'($urandom_range(0, 3));
            load = ($urandom_range(0, 29) == 0);
            if (load) begin
                period = W'($urandom_range(0, 11));
                set_duty(int'($urandom_range(0, 13)), int'($urandom_range(0, 13)));
            end
            cycle();
        end
        load = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
